branch_redirect_unit: RTL

- Parametrised successor to the execute-stage jump/branch target logic.
- Resolves JAL, JALR and all six BRANCH conditions in EX and computes target and link addresses.
- Checks target alignment, then drives a registered redirect to fetch using a valid/ready handshake.
- Holds younger pipeline stages flushed for a configurable number of drain cycles; sits between EX and the fetch PC mux.

---
 rtl/branch_redirect_unit_pkg.sv | 32 +++
 rtl/branch_redirect_unit_if.sv | 23 ++
 rtl/branch_redirect_unit_cmp.sv | 35 +++
 rtl/branch_redirect_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_unit_pkg.sv
// Shared definitions for the branch redirect unit.
// Holds the control-flow opcodes, the branch funct3 codes, the FSM state
// encoding and the target alignment helper.
package branch_redirect_unit_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_REDIRECT = 2'd1,
        S_DRAIN    = 2'd2
    } state_t;

    // With 16-bit alignment only bit 0 matters; with 32-bit alignment both
    // low bits must be clear.
    function automatic logic target_misaligned(input logic [1:0] lsb, input int ialign);
        if (ialign == 16) begin
            return lsb[0];
        end
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/branch_redirect_unit_if.sv
// Redirect channel from the branch redirect unit to the fetch PC mux.
//   redirect_valid : a redirect target is pending (master -> slave)
//   redirect_ready : fetch takes the redirect     (slave -> master)
//   redirect_pc    : new fetch PC                 (master -> slave)
interface branch_redirect_unit_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/branch_redirect_unit_cmp.sv
// Branch condition evaluator (combinational).
//   funct3   : branch condition select
//   rs1, rs2 : source operands
//   cond     : 1 when the selected condition holds; 0 for reserved codes
module branch_cmp
    import branch_redirect_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            cond
);

    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;

    assign rs1_s = rs1;
    assign rs2_s = rs2;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (rs1 == rs2);
            F3_BNE:  cond = (rs1 != rs2);
            F3_BLT:  cond = (rs1_s < rs2_s);
            F3_BGE:  cond = (rs1_s >= rs2_s);
            F3_BLTU: cond = (rs1 < rs2);
            F3_BGEU: cond = (rs1 >= rs2);
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// Execute-stage branch/jump resolution and fetch redirect.
// Resolves JAL, JALR and BRANCH, checks target alignment and drives a
// registered redirect to fetch, then holds younger stages flushed for
// FLUSH_CYCLES drain cycles.
//   clk, rst        : clock, synchronous active-high reset
//   ex_valid/ready  : EX candidate handshake (ready only in IDLE)
//   opcode, funct3, pc, rs1, rs2, imm : EX instruction fields
//   link_addr       : pc+4 (combinational) for JAL/JALR writeback
//   redir           : redirect channel to fetch (valid/ready/pc)
//   flush           : kill all stages younger than EX
//   taken           : one-cycle pulse, accepted instruction redirected
//   misalign_exc    : one-cycle pulse, taken target misaligned
//   misalign_addr   : offending target while misalign_exc=1
module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int IALIGN       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [6:0]             opcode,
    input  logic [2:0]             funct3,
    input  logic [XLEN-1:0]        pc,
    input  logic [XLEN-1:0]        rs1,
    input  logic [XLEN-1:0]        rs2,
    input  logic [XLEN-1:0]        imm,
    output logic [XLEN-1:0]        link_addr,
    branch_redirect_unit_if.master redir,
    output logic                   flush,
    output logic                   taken,
    output logic                   misalign_exc,
    output logic [XLEN-1:0]        misalign_addr
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t          state_q, state_d;
    logic            rv_q, rv_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic            flush_q, flush_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            taken_q, taken_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] maddr_q, maddr_d;

    logic            cond;
    logic            is_taken;
    logic [XLEN-1:0] target;
    logic            accept;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .cond   (cond)
    );

    always_comb begin
        is_taken = 1'b0;
        target   = pc + imm;
        case (opcode)
            OPC_JAL:    is_taken = 1'b1;
            OPC_JALR: begin
                is_taken = 1'b1;
                target   = (rs1 + imm) & ~XLEN'(1);
            end
            OPC_BRANCH: is_taken = cond;
            default:    is_taken = 1'b0;
        endcase
    end

    assign accept    = ex_valid && (state_q == S_IDLE);
    assign ex_ready  = (state_q == S_IDLE);
    assign link_addr = pc + XLEN'(4);

    always_comb begin
        state_d = state_q;
        rv_d    = rv_q;
        rpc_d   = rpc_q;
        flush_d = flush_q;
        cnt_d   = cnt_q;
        taken_d = 1'b0;
        mis_d   = 1'b0;
        maddr_d = '0;
        case (state_q)
            S_IDLE: begin
                if (accept && is_taken) begin
                    if (target_misaligned(target[1:0], IALIGN)) begin
                        mis_d   = 1'b1;
                        maddr_d = target;
                    end else begin
                        rpc_d   = target;
                        rv_d    = 1'b1;
                        flush_d = 1'b1;
                        taken_d = 1'b1;
                        state_d = S_REDIRECT;
                    end
                end
            end
            S_REDIRECT: begin
                if (redir.redirect_ready) begin
                    rv_d = 1'b0;
                    if (FLUSH_CYCLES == 0) begin
                        flush_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = FLUSH_INIT;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leaving on count 1 yields exactly FLUSH_CYCLES drain cycles.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    flush_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                rv_d    = 1'b0;
                flush_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
            taken_q <= 1'b0;
            mis_q   <= 1'b0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            rv_q    <= rv_d;
            rpc_q   <= rpc_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
            taken_q <= taken_d;
            mis_q   <= mis_d;
            maddr_q <= maddr_d;
        end
    end

    assign redir.redirect_valid = rv_q;
    assign redir.redirect_pc    = rpc_q;
    assign flush                = flush_q;
    assign taken                = taken_q;
    assign misalign_exc         = mis_q;
    assign misalign_addr        = maddr_q;

endmodule
